// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM states, byte width and timing constants.
package uart_pkg;

  localparam int unsigned UART_BYTE_W       = 8;
  localparam int unsigned BUSY_TO_DFLT      = 8;
  localparam int unsigned CLKS_PER_BIT_9600 = 5207;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_IDLE = 3'd3,
    DONE      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle shared by the arbiter (master) and its environment (slave).
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*UART_BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic [NUM_REQ-1:0]             err;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_en;
  logic                           tx_busy;

  modport master (
    input  req, req_data, tx_busy,
    output grant, done, err, tx_data, tx_en
  );

  modport slave (
    output req, req_data, tx_busy,
    input  grant, done, err, tx_data, tx_en
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner select: round-robin from a pointer, or lowest index
// when UART_ARB_FIXED_PRIO_EN is defined.
module uart_tx_arbiter_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pend,
`ifndef UART_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

`ifdef UART_ARB_FIXED_PRIO_EN

  // Scan downward so the lowest pending index is the last assignment.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (i_pend[IDX_W'(k)]) begin
        o_idx_c   = IDX_W'(k);
        o_valid_c = 1'b1;
      end
    end
  end

`else

  localparam int unsigned CW = IDX_W + 1;

  logic [CW-1:0] w_cand;

  // Candidate = ptr + k with explicit wrap; downward scan leaves the nearest hit.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_cand = {1'b0, i_ptr} + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (i_pend[w_cand[IDX_W-1:0]]) begin
        o_idx_c   = w_cand[IDX_W-1:0];
        o_valid_c = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters.
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BUSY_TO = BUSY_TO_DFLT
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master io_arb
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;

  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     r_done;
  logic [NUM_REQ-1:0]     r_err;
  logic                   r_tx_en;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;

  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic [NUM_REQ-1:0]     w_done_nxt;
  logic [NUM_REQ-1:0]     w_err_nxt;
  logic                   w_tx_en_nxt;
  logic [UART_BYTE_W-1:0] w_tx_data_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic [NUM_REQ-1:0]     w_pick_oh;
  logic [NUM_REQ-1:0]     w_idx_oh;
  logic                   w_launch;
  logic                   w_timeout;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       w_ptr_nxt;
`endif

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_pend    (io_arb.req),
`ifndef UART_ARB_FIXED_PRIO_EN
    .i_ptr     (r_ptr),
`endif
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  assign w_pick_oh = NUM_REQ'(1) << w_pick_idx;
  assign w_idx_oh  = NUM_REQ'(1) << r_idx;
  assign w_launch  = (r_state == IDLE) && w_pick_valid && !io_arb.tx_busy;
  assign w_timeout = (r_cnt == CNT_W'(BUSY_TO - 1)) && !io_arb.tx_busy;

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_launch) w_state_nxt = LAUNCH;
      LAUNCH:    w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (io_arb.tx_busy) begin
          w_state_nxt = WAIT_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_IDLE: if (!io_arb.tx_busy) w_state_nxt = DONE;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; strobes default low.
  always_comb begin
    w_grant_nxt   = r_grant;
    w_done_nxt    = '0;
    w_err_nxt     = '0;
    w_tx_en_nxt   = r_tx_en;
    w_tx_data_nxt = r_tx_data;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
`ifndef UART_ARB_FIXED_PRIO_EN
    w_ptr_nxt     = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_grant_nxt   = w_pick_oh;
          w_tx_data_nxt = io_arb.req_data[32'(w_pick_idx)*UART_BYTE_W +: UART_BYTE_W];
          w_tx_en_nxt   = 1'b1;
          w_idx_nxt     = w_pick_idx;
          w_cnt_nxt     = '0;
        end
      end
      LAUNCH: w_cnt_nxt = r_cnt + 1'b1;
      WAIT_BUSY: begin
        if (io_arb.tx_busy) begin
          w_tx_en_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          // Pointer untouched so the same requester retries first.
          w_tx_en_nxt = 1'b0;
          w_err_nxt   = w_idx_oh;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      WAIT_IDLE: ;
      DONE: begin
        w_done_nxt  = w_idx_oh;
        w_grant_nxt = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
        w_ptr_nxt   = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
`endif
      end
      default: begin
        w_grant_nxt = '0;
        w_tx_en_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

  assign io_arb.grant   = r_grant;
  assign io_arb.done    = r_done;
  assign io_arb.err     = r_err;
  assign io_arb.tx_en   = r_tx_en;
  assign io_arb.tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 16-clock/bit UART transmitter model.
module tb_uart_tx_arbiter;

  logic sys_clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .BUSY_TO (8)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .io_arb  (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Transmitter model: busy rises two cycles after the tx_en rising edge, 10 bits x 16 clocks.
  logic       busy_gate;
  logic       en_d, start_q, tx_busy_m, tx_line;
  logic [9:0] sh;
  logic [3:0] bitclk, nbits;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d <= 1'b0; start_q <= 1'b0; tx_busy_m <= 1'b0; tx_line <= 1'b1;
      sh <= '0; bitclk <= '0; nbits <= '0;
    end else begin
      en_d    <= bus.tx_en;
      start_q <= bus.tx_en & ~en_d & busy_gate & ~tx_busy_m;
      if (start_q) begin
        tx_busy_m <= 1'b1;
        sh        <= {1'b1, bus.tx_data, 1'b0};
        tx_line   <= 1'b0;
        bitclk    <= '0;
        nbits     <= '0;
      end else if (tx_busy_m) begin
        if (bitclk == 4'd15) begin
          bitclk <= '0;
          if (nbits == 4'd9) begin
            tx_busy_m <= 1'b0;
            tx_line   <= 1'b1;
          end else begin
            nbits   <= nbits + 4'd1;
            tx_line <= sh[nbits + 4'd1];
          end
        end else begin
          bitclk <= bitclk + 4'd1;
        end
      end
    end
  end

  assign bus.tx_busy = tx_busy_m;

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a grant, check it, follow the frame to done, then drop the requesters in drop.
  task automatic run_frame(input string tag, input logic [3:0] g, input logic [7:0] d,
                           input logic [3:0] drop);
    int   n;
    logic stable;
    n = 0;
    while (bus.grant === 4'b0 && n < 40) begin tick(); n++; end
    chk({tag, "/grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "/tx_data"}, 32'(bus.tx_data), 32'(d));
    chk({tag, "/tx_en"}, 32'(bus.tx_en), 32'd1);
    stable = 1'b1;
    n = 0;
    while (bus.done === 4'b0 && n < 400) begin
      tick(); n++;
      if (bus.tx_data !== d) stable = 1'b0;
    end
    chk({tag, "/data_held"}, 32'(stable), 32'd1);
    chk({tag, "/done"}, 32'(bus.done), 32'(g));
    chk({tag, "/tx_en_low_at_done"}, 32'(bus.tx_en), 32'd0);
    bus.req = bus.req & ~drop;
    tick();
    chk({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         fall;
    logic       prev;
    logic       stable;
    logic [9:0] bits;

    rst_n        = 1'b0;
    busy_gate    = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    tick(); tick();
    chk("rst/grant",   32'(bus.grant),   32'd0);
    chk("rst/done",    32'(bus.done),    32'd0);
    chk("rst/err",     32'(bus.err),     32'd0);
    chk("rst/tx_en",   32'(bus.tx_en),   32'd0);
    chk("rst/tx_data", 32'(bus.tx_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // All four requesting, each drops on its done: order 0,1,2,3.
    bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    bus.req      = 4'b1111;
    run_frame("all0", 4'b0001, 8'h10, 4'b0001);
    run_frame("all1", 4'b0010, 8'h21, 4'b0010);
    run_frame("all2", 4'b0100, 8'h32, 4'b0100);
    run_frame("all3", 4'b1000, 8'h43, 4'b1000);
    chk("all/req_cleared", 32'(bus.req), 32'd0);

    // Fairness with req0 and req2 held continuously.
    bus.req = 4'b0101;
`ifdef UART_ARB_FIXED_PRIO_EN
    run_frame("fair0", 4'b0001, 8'h10, 4'b0000);
    run_frame("fair1", 4'b0001, 8'h10, 4'b0000);
    run_frame("fair2", 4'b0001, 8'h10, 4'b0101);
`else
    run_frame("fair0", 4'b0001, 8'h10, 4'b0000);
    run_frame("fair1", 4'b0100, 8'h32, 4'b0000);
    run_frame("fair2", 4'b0001, 8'h10, 4'b0000);
    run_frame("fair3", 4'b0100, 8'h32, 4'b0101);
`endif
    tick(); tick();

    // Single request with serial-line check.
    bus.req_data[15:8] = 8'hA5;
    bus.req            = 4'b0010;
    tick();
    chk("single/grant",   32'(bus.grant),   32'h2);
    chk("single/tx_en",   32'(bus.tx_en),   32'd1);
    chk("single/tx_data", 32'(bus.tx_data), 32'hA5);
    tick(); tick();
    chk("single/tx_en_c3", 32'(bus.tx_en), 32'd1);
    tick();
    chk("single/tx_en_c4", 32'(bus.tx_en), 32'd0);
    repeat (7) tick();
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      bits[i] = tx_line;
      if (i < 9) repeat (16) tick();
    end
    chk("single/serial", 32'(bits), 32'(10'b1101001010));
    n = 0; fall = -100; prev = bus.tx_busy; stable = 1'b1;
    while (bus.done === 4'b0 && n < 60) begin
      tick(); n++;
      if (prev && !bus.tx_busy) fall = n;
      prev = bus.tx_busy;
      if (bus.tx_data !== 8'hA5) stable = 1'b0;
    end
    chk("single/done",      32'(bus.done), 32'h2);
    chk("single/done_lat",  32'(n - fall), 32'd2);
    chk("single/data_held", 32'(stable),   32'd1);
    bus.req = '0;
    tick();
    chk("single/done_pulse", 32'(bus.done),  32'd0);
    chk("single/grant_rel",  32'(bus.grant), 32'd0);

    // Timeout: transmitter never goes busy.
    busy_gate          = 1'b0;
    bus.req_data[31:24] = 8'h77;
    bus.req            = 4'b1000;
    tick();
    n = 0;
    while (bus.tx_en === 1'b1 && n < 50) begin n++; tick(); end
    chk("to/tx_en_cycles", 32'(n),         32'd8);
    chk("to/err",          32'(bus.err),   32'h8);
    chk("to/no_done",      32'(bus.done),  32'd0);
    chk("to/grant_rel",    32'(bus.grant), 32'd0);
    tick();
    chk("to/regrant", 32'(bus.grant), 32'h8);
    chk("to/relaunch", 32'(bus.tx_en), 32'd1);
    n = 0;
    while (bus.err === 4'b0 && n < 20) begin tick(); n++; end
    chk("to/err2", 32'(bus.err), 32'h8);
    bus.req = '0;
    tick();
    busy_gate = 1'b1;
    tick();

    // Late withdrawal: req1 drops one cycle after grant.
    bus.req_data[15:8] = 8'h3C;
    bus.req            = 4'b0010;
    tick();
    chk("late/grant", 32'(bus.grant), 32'h2);
    tick();
    bus.req = '0;
    n = 0;
    while (bus.done === 4'b0 && n < 400) begin tick(); n++; end
    chk("late/done",    32'(bus.done),    32'h2);
    chk("late/tx_data", 32'(bus.tx_data), 32'h3C);
    tick();

    // Reset in the middle of data bit 4, then resume with req3.
    bus.req_data[31:24] = 8'hC3;
    bus.req             = 4'b1000;
    n = 0;
    while (bus.tx_busy === 1'b0 && n < 40) begin tick(); n++; end
    chk("mid/busy", 32'(bus.tx_busy), 32'd1);
    repeat (72) tick();
    rst_n = 1'b0;
    #1;
    chk("mid/tx_en",   32'(bus.tx_en),   32'd0);
    chk("mid/grant",   32'(bus.grant),   32'd0);
    chk("mid/tx_data", 32'(bus.tx_data), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    run_frame("resume", 4'b1000, 8'hC3, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART byte transmitter among NUM_REQ requesters. It selects one pending requester, presents that requester's byte to the transmitter and raises the transmitter's start strobe. It then tracks the transmitter's busy flag through the full frame and returns a one-cycle done pulse to the served requester. It sits between client logic (command responders, status reporters) and the single UART transmitter on the serial pin.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
BUSY_TO, 8, cycles to wait for the transmitter busy flag to rise after the start strobe; legal range 4..255.

Ports:
sys_clk  input  1  system clock
rst_n  input  1  reset
req  input  NUM_REQ  per-requester request level; held high until that requester's done or err
req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]; stable while req[i]=1
grant  output  NUM_REQ  one-hot, marks the requester being served
done  output  NUM_REQ  one-cycle pulse on the served index when its frame has finished
err  output  NUM_REQ  one-cycle pulse on the served index when BUSY_TO expired
tx_data  output  8  byte to the transmitter parallel input
tx_en  output  1  start strobe to the transmitter (transmitter starts on the rising edge)
tx_busy  input  1  transmitter busy flag, high during the frame

Behaviour:
- Reset (rst_n is the reset: asynchronous, active-low; sys_clk is the clock): state=IDLE, grant=0, done=0, err=0, tx_en=0, tx_data=8'h00, rr pointer=0, timeout counter=0. All outputs are registered.
- IDLE:
  - Launches only when req!=0 and tx_busy=0.
  - Winner is the first set req bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - On the next edge: grant=onehot(winner), tx_data=req_data[winner] latched, go to LAUNCH.
- LAUNCH: tx_en=1 from this cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_en stays 1 and the counter increments each cycle.
  - If tx_busy=1: tx_en=0, counter cleared, go to WAIT_IDLE.
  - If the counter reaches BUSY_TO-1 with tx_busy still 0: tx_en=0, err[winner]=1 for one cycle, grant=0, rr pointer unchanged (the same requester wins next if still requesting), go to IDLE.
- WAIT_IDLE: tx_data and grant held. When tx_busy=0, go to DONE.
- DONE: done[winner]=1 for exactly one cycle, grant=0, rr pointer=(winner+1) mod NUM_REQ, go to IDLE. tx_en has been 0 for at least 2 cycles before any relaunch, which guarantees a fresh rising edge.
- Latency: req high in IDLE cycle 0 -> grant/tx_data valid cycle 1 -> tx_en=1 cycle 1. With a transmitter whose busy rises 2 cycles after the strobe, tx_en drops at cycle 4. done fires 2 cycles after tx_busy falls.
- tx_data never changes between LAUNCH and DONE.
- A requester dropping req after grant does not abort the transfer; the frame completes and done still pulses.
- Requests arriving during a transfer wait; there is no preemption.
- At most one bit of grant, done or err is set in any cycle; done and err never coincide.
- Reset mid-frame returns immediately to reset values. The transmitter is reset by the same rst_n.
- Index width is $clog2(NUM_REQ); pointer wrap uses explicit compare, not power-of-two truncation.

Optional Feature:
UART_ARB_FIXED_PRIO_EN:
- Defined: lowest-index pending requester always wins; rr pointer is removed; err retry behaviour is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, DONE)
  - UART_BYTE_W=8
  - default BUSY_TO
  - shared CLKS_PER_BIT_9600=5207 constant
- One natural sub-module: rr_pick (combinational pending-mask + pointer -> winner index + valid), which is replaceable by a fixed-priority encoder under the macro.

Test Plan:
Bench setup: NUM_REQ=4, BUSY_TO=8, paired with the team's UART transmitter with its bit-period count overridden to 15 (16 clocks/bit).
- Single request: req=4'b0010, req_data[15:8]=8'hA5 -> grant=4'b0010 and tx_en=1 one cycle later, tx_data=8'hA5 held throughout; the serial line shows 0,1,0,1,0,0,1,0,1,1 at 16 clocks/bit; done=4'b0010 pulses once; grant returns to 0.
- All four requesting, with req_data 8'h10/8'h21/8'h32/8'h43, each dropping req on its done -> serve order 0,1,2,3 and four done pulses.
- Fairness: req0 and req2 held continuously -> serve order 0,2,0,2. Under UART_ARB_FIXED_PRIO_EN the order is 0,0,0.
- Timeout: busy tied to 0, req=4'b1000 -> tx_en high exactly 8 cycles, then err=4'b1000 pulse with no done; with req still high, relaunch to the same index after 2 cycles.
- Late withdrawal: req1 drops one cycle after grant -> the frame still completes and done[1] pulses.
- Reset asserted mid-frame (bit 4) -> tx_en, grant and tx_data clear immediately; after release, a pending req3 is served normally.
